// File: rtl/mem_stage_pkg.sv
// Shared RV32I packet types for the MEM stage slice: opcodes, load/store funct3
// encodings, the EX/MEM packet layout and the MEM access FSM states.
package mem_stage_pkg;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode_t;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    typedef struct packed {
        rv32i_opcode_t opcode;
        logic [2:0]    funct3;
        logic [4:0]    rd;
    } rv32i_inst_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_out;
        logic [31:0] rs2_out;
        logic [31:0] mem_rdata;
    } rv32i_data_t;

    typedef struct packed {
        logic        valid;
        rv32i_inst_t inst;
        rv32i_data_t data;
    } rv32i_packet_t;

    function automatic logic is_mem_op(input rv32i_packet_t p);
        return p.valid && ((p.inst.opcode == op_load) || (p.inst.opcode == op_store));
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: selects the addressed byte/halfword of a cache word and
// sign- or zero-extends it according to the load funct3.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] ext
);

    logic [31:0] byte_s;
    logic [31:0] half_s;

    // Lane select and extension; halfwords only look at addr[1]
    always_comb begin
        byte_s = rdata >> {addr, 3'b000};
        half_s = rdata >> {addr[1], 4'b0000};
        ext    = rdata;
        case (load_funct3_t'(funct3))
            lb:      ext = {{24{byte_s[7]}}, byte_s[7:0]};
            lbu:     ext = {24'h000000, byte_s[7:0]};
            lh:      ext = {{16{half_s[15]}}, half_s[15:0]};
            lhu:     ext = {16'h0000, half_s[15:0]};
            lw:      ext = rdata;
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: converts load/store packets into one data-cache transaction,
// stalls the pipeline while it is outstanding and returns aligned load data.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  rv32i_packet_t mem_in,
    output rv32i_packet_t mem_out,
    output logic          mem_stall,
    output logic          data_read,
    output logic          data_write,
    output logic [3:0]    data_mbe,
    output logic [31:0]   data_addr,
    output logic [31:0]   data_wdata,
    input  logic [31:0]   data_rdata,
    input  logic          data_resp
);

    mem_state_t  state_r;
    mem_state_t  state_nxt_s;
    logic        mem_op_s;
    logic        is_store_s;
    logic [3:0]  mbe_s;
    logic [31:0] wdata_s;
    logic [31:0] aligned_s;

    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  mbe_r;
    logic        is_store_r;
    logic [31:0] rdata_r;
    logic        read_r;
    logic        write_r;

    assign mem_op_s   = is_mem_op(mem_in);
    assign is_store_s = (mem_in.inst.opcode == op_store);

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (mem_op_s) state_nxt_s = ACCESS;
                else          state_nxt_s = IDLE;
            end
            ACCESS: begin
                if (data_resp) state_nxt_s = DONE;
                else           state_nxt_s = ACCESS;
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Stall: an arriving memory op holds the pipeline in the same cycle
    always_comb begin
        mem_stall = 1'b0;
        case (state_r)
            IDLE:    mem_stall = mem_op_s;
            ACCESS:  mem_stall = 1'b1;
            DONE:    mem_stall = 1'b0;
            default: mem_stall = 1'b0;
        endcase
    end

    // Store byte-lane and data placement
    always_comb begin
        mbe_s   = 4'b0000;
        wdata_s = 32'h0000_0000;
        if (is_store_s) begin
            case (store_funct3_t'(mem_in.inst.funct3))
                sw: begin
                    mbe_s   = 4'b1111;
                    wdata_s = mem_in.data.rs2_out;
                end
                sh: begin
                    mbe_s   = 4'b0011 << {mem_in.data.alu_out[1], 1'b0};
                    wdata_s = mem_in.data.rs2_out << {mem_in.data.alu_out[1], 4'b0000};
                end
                sb: begin
                    mbe_s   = 4'b0001 << mem_in.data.alu_out[1:0];
                    wdata_s = mem_in.data.rs2_out << {mem_in.data.alu_out[1:0], 3'b000};
                end
                default: begin
                    mbe_s   = 4'b0000;
                    wdata_s = mem_in.data.rs2_out;
                end
            endcase
        end else begin
            mbe_s   = 4'b0000;
            wdata_s = 32'h0000_0000;
        end
    end

    // State, request registers and captured read data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            addr_r     <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
            mbe_r      <= 4'b0000;
            is_store_r <= 1'b0;
            rdata_r    <= 32'h0000_0000;
            read_r     <= 1'b0;
            write_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if ((state_r == IDLE) && mem_op_s) begin
                addr_r     <= mem_in.data.alu_out;
                wdata_r    <= wdata_s;
                mbe_r      <= mbe_s;
                is_store_r <= is_store_s;
                read_r     <= !is_store_s;
                write_r    <= is_store_s;
            end else if ((state_r == ACCESS) && data_resp) begin
                rdata_r <= data_rdata;
                read_r  <= 1'b0;
                write_r <= 1'b0;
            end
        end
    end

    assign data_read  = read_r;
    assign data_write = write_r;
    assign data_mbe   = mbe_r;
    assign data_addr  = {addr_r[31:2], 2'b00};
    assign data_wdata = wdata_r;

    load_align u_load_align (
        .rdata  (rdata_r),
        .addr   (addr_r[1:0]),
        .funct3 (mem_in.inst.funct3),
        .ext    (aligned_s)
    );

    // Outgoing packet; load data only appears while the result is presented
    always_comb begin
        mem_out = mem_in;
        if ((state_r == DONE) && !is_store_r) begin
            mem_out.data.mem_rdata = aligned_s;
        end else begin
            mem_out.data.mem_rdata = 32'h0000_0000;
        end
    end

endmodule
